// File: rtl/iob_fp_acc.sv
// Floating-point sum reduction controller: streams len_i elements through an
// external single-outstanding adder and reports the final sum on res_o.
module iob_fp_acc #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              add_start_o,
    output logic [DATA_W-1:0] add_op_a_o,
    output logic [DATA_W-1:0] add_op_b_o,
    input  logic              add_done_i,
    input  logic [DATA_W-1:0] add_res_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] res_o
);

    if (EXP_W < 2 || EXP_W > DATA_W - 2) begin : g_bad_exp_w
        $error("EXP_W must leave room for sign and mantissa within DATA_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_IN,
        WAIT_ADD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              in_ready_q, in_ready_d;
    logic              add_start_q, add_start_d;
    logic              done_q, done_d;
    logic              in_hs;

    assign in_hs = in_valid_i & in_ready_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        add_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d = len_i;
                    cnt_d = '0;
                    if (len_i != '0) begin
                        state_d = LOAD;
                    end else begin
                        acc_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            // First element seeds the accumulator directly; the adder never sees a zero operand.
            LOAD: begin
                if (in_hs) begin
                    acc_d   = in_data_i;
                    cnt_d   = LEN_W'(1);
                    state_d = (len_q == LEN_W'(1)) ? DONE : WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (in_hs) begin
                    op_a_d      = acc_q;
                    op_b_d      = in_data_i;
                    add_start_d = 1'b1;
                    state_d     = WAIT_ADD;
                end
            end
            WAIT_ADD: begin
                if (add_done_i) begin
                    acc_d   = add_res_i;
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_d == len_q) ? DONE : WAIT_IN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        in_ready_d = (state_d == LOAD) || (state_d == WAIT_IN);
        done_d     = (state_d == DONE);
        if (state_d == DONE) begin
            res_d = acc_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b0;
            add_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            add_start_q <= add_start_d;
            done_q      <= done_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign add_start_o = add_start_q;
    assign add_op_a_o  = op_a_q;
    assign add_op_b_o  = op_b_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign res_o       = res_q;

endmodule

// File: tb/tb_iob_fp_acc.sv
// Bench for iob_fp_acc: real-valued sum model plus a behavioural float adder
// with programmable latency, checked on every falling edge.
module tb_iob_fp_acc;
    localparam int DATA_W = 32;
    localparam int EXP_W  = 8;
    localparam int LEN_W  = 16;

    logic              clk_i      = 1'b0;
    logic              arst_n_i   = 1'b0;
    logic              start_i    = 1'b0;
    logic [LEN_W-1:0]  len_i      = '0;
    logic              in_valid_i = 1'b0;
    logic [DATA_W-1:0] in_data_i  = '0;
    logic              add_done_i = 1'b0;
    logic [DATA_W-1:0] add_res_i  = '0;
    logic              in_ready_o;
    logic              add_start_o;
    logic [DATA_W-1:0] add_op_a_o;
    logic [DATA_W-1:0] add_op_b_o;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] res_o;

    iob_fp_acc #(.DATA_W(DATA_W), .EXP_W(EXP_W), .LEN_W(LEN_W)) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .add_start_o(add_start_o),
        .add_op_a_o (add_op_a_o),
        .add_op_b_o (add_op_b_o),
        .add_done_i (add_done_i),
        .add_res_i  (add_res_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .res_o      (res_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-precision <-> real for normal numbers and zero.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // Behavioural adder: one operation at a time, latency drawn from [lat_min, lat_max].
    int unsigned lat_min = 5;
    int unsigned lat_max = 5;
    int unsigned lat_cur;
    bit          adder_busy = 1'b0;
    logic [31:0] ad_a, ad_b;

    always begin
        @(negedge clk_i);
        if (arst_n_i && add_start_o) begin
            ad_a       = add_op_a_o;
            ad_b       = add_op_b_o;
            adder_busy = 1'b1;
            lat_cur    = $urandom_range(lat_max, lat_min);
            repeat (lat_cur) @(posedge clk_i);
            #1;
            add_done_i = 1'b1;
            add_res_i  = r2f(f2r(ad_a) + f2r(ad_b));
            @(posedge clk_i);
            #1;
            add_done_i = 1'b0;
            add_res_i  = '0;
            adder_busy = 1'b0;
        end
    end

    // Reference model: a reduction is a running real-valued sum of accepted elements.
    bit          active, awaiting, start_nx, done_nx;
    int unsigned m_len, m_cnt, m_adds;
    real         m_sum;
    logic [31:0] m_a, m_b, last_res;
    int unsigned n_add = 0, n_done = 0, n_busy = 0;
    logic [31:0] cap_op_a[$];
    logic [31:0] cap_res = '0;

    always @(negedge clk_i) begin
        if (!arst_n_i) begin
            chk("rst_busy", busy_o, 1'b0);
            chk("rst_done", done_o, 1'b0);
            chk("rst_in_ready", in_ready_o, 1'b0);
            chk("rst_add_start", add_start_o, 1'b0);
            chk("rst_op_a", add_op_a_o, 32'd0);
            chk("rst_op_b", add_op_b_o, 32'd0);
            chk("rst_res", res_o, 32'd0);
            active   = 1'b0;
            awaiting = 1'b0;
            start_nx = 1'b0;
            done_nx  = 1'b0;
            last_res = '0;
        end else begin
            chk("busy", busy_o, active);
            chk("done", done_o, done_nx);
            chk("add_start", add_start_o, start_nx);
            chk("in_ready", in_ready_o, active && !awaiting && !done_nx);
            if (awaiting) begin
                chk("op_a", add_op_a_o, m_a);
                chk("op_b", add_op_b_o, m_b);
            end
            if (busy_o) n_busy++;
            if (add_start_o) begin
                n_add++;
                m_adds++;
                cap_op_a.push_back(add_op_a_o);
            end
            if (done_o) begin
                n_done++;
                cap_res = res_o;
            end
            if (done_nx) begin
                last_res = r2f(m_sum);
                chk("adds_per_reduction", m_adds, (m_len == 0) ? 0 : m_len - 1);
            end
            chk("res", res_o, last_res);

            // Events the DUT will act on at the coming rising edge.
            start_nx = 1'b0;
            if (done_nx) begin
                done_nx = 1'b0;
                active  = 1'b0;
            end else if (!active && start_i) begin
                active = 1'b1;
                m_len  = int'(len_i);
                m_cnt  = 0;
                m_adds = 0;
                m_sum  = 0.0;
                if (m_len == 0) done_nx = 1'b1;
            end else if (active && !awaiting && in_valid_i && in_ready_o) begin
                if (m_cnt == 0) begin
                    m_sum = f2r(in_data_i);
                    m_cnt = 1;
                    if (m_len == 1) done_nx = 1'b1;
                end else begin
                    m_a      = r2f(m_sum);
                    m_b      = in_data_i;
                    m_sum    = m_sum + f2r(in_data_i);
                    awaiting = 1'b1;
                    start_nx = 1'b1;
                end
            end else if (awaiting && add_done_i) begin
                awaiting = 1'b0;
                m_cnt++;
                if (m_cnt == m_len) done_nx = 1'b1;
            end
        end
    end

    logic [31:0] stim_q[$];

    task automatic do_start(input int unsigned len);
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic feed(input int unsigned n, input int unsigned gap_pct);
        int unsigned sent  = 0;
        int unsigned guard = 0;
        bit          hs;
        while (sent < n && guard < 5000) begin
            if (!in_valid_i && $urandom_range(99, 0) >= gap_pct) begin
                in_valid_i = 1'b1;
                if (stim_q.size() > 0) in_data_i = stim_q.pop_front();
                else in_data_i = r2f(real'($urandom_range(1000, 1)));
            end
            @(negedge clk_i);
            hs = in_valid_i && in_ready_o;
            @(posedge clk_i);
            #1;
            if (hs) begin
                sent++;
                in_valid_i = 1'b0;
            end
            guard++;
        end
        in_valid_i = 1'b0;
        if (guard >= 5000) chk("feed_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n = 0;
        bit          seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk_i);
            seen = done_o;
            n++;
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
    endtask

    int unsigned a0, d0, b0, g;

    initial begin
        // Reset, with start_i already waiting so it is taken on the first edge after release.
        start_i = 1'b1;
        len_i   = LEN_W'(3);
        stim_q  = '{32'h3F800000, 32'h40000000, 32'h40400000};
        cap_op_a.delete();
        repeat (3) @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;
        a0 = n_add;
        d0 = n_done;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        feed(3, 0);
        wait_done(200);
        chk("d1_adds", n_add - a0, 2);
        chk("d1_second_op_a", (cap_op_a.size() > 1) ? cap_op_a[1] : 32'hDEAD, 32'h40400000);
        chk("d1_res", cap_res, 32'h40C00000);
        chk("d1_dones", n_done - d0, 1);

        // Single element: loaded directly, no adder use.
        a0 = n_add;
        d0 = n_done;
        stim_q = '{32'h3F800000};
        do_start(1);
        feed(1, 0);
        wait_done(20);
        chk("d2_adds", n_add - a0, 0);
        chk("d2_res", cap_res, 32'h3F800000);
        chk("d2_dones", n_done - d0, 1);

        // Empty reduction.
        d0 = n_done;
        b0 = n_busy;
        do_start(0);
        wait_done(20);
        chk("d3_res", cap_res, 32'h00000000);
        chk("d3_busy_cycles", n_busy - b0, 1);
        chk("d3_dones", n_done - d0, 1);

        // Gappy input stream.
        a0 = n_add;
        d0 = n_done;
        do_start(4);
        feed(4, 50);
        wait_done(200);
        chk("d4_adds", n_add - a0, 3);
        chk("d4_dones", n_done - d0, 1);

        // start_i during WAIT_ADD must not disturb the running reduction.
        a0 = n_add;
        d0 = n_done;
        do_start(3);
        fork
            feed(3, 0);
            begin
                g = 0;
                while (!add_start_o && g < 200) begin
                    @(negedge clk_i);
                    g++;
                end
                if (g >= 200) chk("d5_add_wait_timeout", 1'b0, 1'b1);
                start_i = 1'b1;
                len_i   = LEN_W'(7);
                @(posedge clk_i);
                #1;
                start_i = 1'b0;
            end
        join
        wait_done(200);
        chk("d5_adds", n_add - a0, 2);
        chk("d5_dones", n_done - d0, 1);

        // Reset while an add is in flight; its done arrives after release.
        d0 = n_done;
        do_start(4);
        feed(2, 0);
        repeat (2) @(posedge clk_i);
        #3;
        arst_n_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;
        g = 0;
        while (!add_done_i && g < 50) begin
            @(negedge clk_i);
            g++;
        end
        chk("d6_late_done_seen", add_done_i, 1'b1);
        g = 0;
        while (adder_busy && g < 50) begin
            @(posedge clk_i);
            g++;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk("d6_no_done", n_done - d0, 0);
        chk("d6_idle", busy_o, 1'b0);
        chk("d6_res_zero", res_o, 32'd0);
        d0 = n_done;
        do_start(5);
        feed(5, 20);
        wait_done(300);
        chk("d6_next_dones", n_done - d0, 1);

        // Randomised reductions with varying length, gaps and adder latency.
        lat_min = 1;
        lat_max = 8;
        for (int i = 0; i < 10; i++) begin
            int unsigned len;
            len = $urandom_range(12, 0);
            d0  = n_done;
            do_start(len);
            feed(len, $urandom_range(60, 0));
            wait_done(400);
            chk("rand_dones", n_done - d0, 1);
        end

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
